// File: rtl/wdb_agent_if.sv
// Bus bundle between the WDB agent and its surroundings: upstream entry
// allocation and data-write handshakes, arbiter dataram-write requests,
// the WDB macro port, the dataram write strobe and the ROB completion.
//   slave  : the agent side (wdb_agent)
//   master : the environment side (upstream, arbiter, WDB macro, ROB)
interface wdb_agent_if #(
   parameter int ENTRY_ID_WIDTH = 4,
   parameter int ROB_ID_WIDTH   = 6,
   parameter int TXNID_WIDTH    = 8
);
   logic                      alloc_vld;
   logic [ENTRY_ID_WIDTH-1:0] alloc_idx;
   logic                      alloc_rdy;

   logic                      us_wr_vld;
   logic [ENTRY_ID_WIDTH-1:0] us_wr_idx;
   logic                      us_wr_rdy;

   logic                      dataram_wr_vld;
   logic [ENTRY_ID_WIDTH-1:0] dataram_wr_entry_id;
   logic [ROB_ID_WIDTH-1:0]   dataram_wr_rob_id;
   logic [TXNID_WIDTH-1:0]    dataram_wr_txnid;
   logic                      dataram_wr_rdy;

   logic                      WDB_rdy;
   logic                      wdb_mem_en;
   logic                      wdb_wr_en;
   logic [ENTRY_ID_WIDTH-1:0] wdb_addr;

   logic                      sram_wr_vld;
   logic [ENTRY_ID_WIDTH-1:0] sram_wr_entry_id;
   logic [TXNID_WIDTH-1:0]    sram_wr_txnid;

   logic                      wr_done;
   logic [ROB_ID_WIDTH-1:0]   wr_done_idx;
   logic                      err;

   modport slave (
      output alloc_vld, alloc_idx,
      input  alloc_rdy,
      input  us_wr_vld, us_wr_idx,
      output us_wr_rdy,
      input  dataram_wr_vld, dataram_wr_entry_id, dataram_wr_rob_id, dataram_wr_txnid,
      output dataram_wr_rdy,
      input  WDB_rdy,
      output wdb_mem_en, wdb_wr_en, wdb_addr,
      output sram_wr_vld, sram_wr_entry_id, sram_wr_txnid,
      output wr_done, wr_done_idx, err
   );

   modport master (
      input  alloc_vld, alloc_idx,
      output alloc_rdy,
      output us_wr_vld, us_wr_idx,
      input  us_wr_rdy,
      output dataram_wr_vld, dataram_wr_entry_id, dataram_wr_rob_id, dataram_wr_txnid,
      input  dataram_wr_rdy,
      output WDB_rdy,
      input  wdb_mem_en, wdb_wr_en, wdb_addr,
      input  sram_wr_vld, sram_wr_entry_id, sram_wr_txnid,
      input  wr_done, wr_done_idx, err
   );
endinterface

// File: rtl/wdb_agent.sv
// Write data buffer agent. Hands out free WDB entries to upstream, accepts
// upstream data writes into them, accepts arbiter-granted dataram writes for
// entries holding data, reads those entries out over a fixed-latency pipe,
// strobes the dataram write, then reports completion to the ROB and returns
// the entry to the free pool.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active high
//   bus  : wdb_agent_if.slave (alloc, us_wr, dataram_wr, WDB port,
//          sram write strobe, wr_done, sticky err)
//
// Per-entry state:
//   state    | meaning
//   ST_FREE  | in the free pool, may be offered on alloc
//   ST_ALLOC | handed to upstream, waiting for its data write
//   ST_FULL  | data present, waiting for a dataram write grant
//   ST_DRAIN | read-out in flight, freed on its wr_done cycle
module wdb_agent #(
   parameter int ENTRY_NUM        = 16,
   parameter int ENTRY_ID_WIDTH   = $clog2(ENTRY_NUM),
   parameter int ROB_ID_WIDTH     = 6,
   parameter int TXNID_WIDTH      = 8,
   parameter int WRITE_SRAM_DELAY = 4,
   parameter int WR_DONE_DELAY    = 8
) (
   input  logic       clk,
   input  logic       rst,
   wdb_agent_if.slave bus
);

   typedef enum logic [1:0] {
      ST_FREE  = 2'd0,
      ST_ALLOC = 2'd1,
      ST_FULL  = 2'd2,
      ST_DRAIN = 2'd3
   } ent_state_e;

   localparam int LAST = WR_DONE_DELAY - 1;
   localparam int SRAM = WRITE_SRAM_DELAY - 1;

   ent_state_e                state_q [ENTRY_NUM];
   ent_state_e                state_d [ENTRY_NUM];

   logic                      pvld_q [WR_DONE_DELAY];
   logic                      pvld_d [WR_DONE_DELAY];
   logic [ENTRY_ID_WIDTH-1:0] pent_q [WR_DONE_DELAY];
   logic [ENTRY_ID_WIDTH-1:0] pent_d [WR_DONE_DELAY];
   logic [ROB_ID_WIDTH-1:0]   prob_q [WR_DONE_DELAY];
   logic [ROB_ID_WIDTH-1:0]   prob_d [WR_DONE_DELAY];
   logic [TXNID_WIDTH-1:0]    ptxn_q [WR_DONE_DELAY];
   logic [TXNID_WIDTH-1:0]    ptxn_d [WR_DONE_DELAY];

   logic                      err_q;
   logic                      err_d;

   logic                      alloc_vld;
   logic [ENTRY_ID_WIDTH-1:0] alloc_idx;
   logic                      alloc_hs;
   logic                      us_wr_hs;
   logic                      dr_rdy;
   logic                      dr_hs;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRY_NUM; i++) state_q[i] <= ST_FREE;
         for (int k = 0; k < WR_DONE_DELAY; k++) begin
            pvld_q[k] <= 1'b0;
            pent_q[k] <= '0;
            prob_q[k] <= '0;
            ptxn_q[k] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < ENTRY_NUM; i++) state_q[i] <= state_d[i];
         for (int k = 0; k < WR_DONE_DELAY; k++) begin
            pvld_q[k] <= pvld_d[k];
            pent_q[k] <= pent_d[k];
            prob_q[k] <= prob_d[k];
            ptxn_q[k] <= ptxn_d[k];
         end
         err_q <= err_d;
      end
   end

   // Output / handshake decode
   always_comb begin
      alloc_vld = 1'b0;
      alloc_idx = '0;
      // Scan downward so the last hit is the lowest free index.
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (state_q[i] == ST_FREE) begin
            alloc_vld = 1'b1;
            alloc_idx = ENTRY_ID_WIDTH'(i);
         end
      end
      alloc_hs = alloc_vld & bus.alloc_rdy;
      // The single WDB port goes to the upstream write first.
      us_wr_hs = bus.us_wr_vld & bus.WDB_rdy;
      dr_rdy   = bus.WDB_rdy & ~bus.us_wr_vld &
                 (state_q[bus.dataram_wr_entry_id] == ST_FULL);
      dr_hs    = bus.dataram_wr_vld & dr_rdy;
   end

   // Next state
   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) state_d[i] = state_q[i];
      err_d = err_q;

      // The draining entry cannot collide with the other updates: alloc only
      // touches FREE entries and the dataram grant only FULL ones.
      if (pvld_q[LAST]) state_d[pent_q[LAST]] = ST_FREE;
      if (alloc_hs) state_d[alloc_idx] = ST_ALLOC;
      if (us_wr_hs) begin
         if (state_q[bus.us_wr_idx] == ST_ALLOC) state_d[bus.us_wr_idx] = ST_FULL;
         else                                    err_d = 1'b1;
      end
      if (dr_hs) state_d[bus.dataram_wr_entry_id] = ST_DRAIN;
      if (bus.alloc_rdy & ~alloc_vld) err_d = 1'b1;

      // Idle stages carry zero payload so the strobe outputs read 0 when idle.
      pvld_d[0] = dr_hs;
      pent_d[0] = dr_hs ? bus.dataram_wr_entry_id : '0;
      prob_d[0] = dr_hs ? bus.dataram_wr_rob_id   : '0;
      ptxn_d[0] = dr_hs ? bus.dataram_wr_txnid    : '0;
      for (int k = 1; k < WR_DONE_DELAY; k++) begin
         pvld_d[k] = pvld_q[k-1];
         pent_d[k] = pent_q[k-1];
         prob_d[k] = prob_q[k-1];
         ptxn_d[k] = ptxn_q[k-1];
      end
   end

   assign bus.alloc_vld        = alloc_vld;
   assign bus.alloc_idx        = alloc_idx;
   assign bus.us_wr_rdy        = bus.WDB_rdy;
   assign bus.dataram_wr_rdy   = dr_rdy;
   assign bus.wdb_mem_en       = us_wr_hs | dr_hs;
   assign bus.wdb_wr_en        = us_wr_hs;
   assign bus.wdb_addr         = us_wr_hs ? bus.us_wr_idx : bus.dataram_wr_entry_id;
   assign bus.sram_wr_vld      = pvld_q[SRAM];
   assign bus.sram_wr_entry_id = pent_q[SRAM];
   assign bus.sram_wr_txnid    = ptxn_q[SRAM];
   assign bus.wr_done          = pvld_q[LAST];
   assign bus.wr_done_idx      = prob_q[LAST];
   assign bus.err              = err_q;

endmodule
